// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants, FSM state encoding and header layout
// for the transmit generator and the receive-side detector.
package eth_pkg;

    localparam int unsigned HDR_BYTES       = 14;
    localparam int unsigned HDR_W           = HDR_BYTES * 8;
    localparam int unsigned LEN_W           = 11;
    localparam int unsigned IDX_W           = 4;
    localparam int unsigned MIN_PAYLOAD_DEF = 46;
    localparam int unsigned MAX_PAYLOAD_DEF = 1500;
    localparam int unsigned IFG_CYCLES_DEF  = 12;

    // Byte offsets of each header field within the serialised header
    localparam int unsigned DEST_OFF = 0;
    localparam int unsigned SRC_OFF  = 6;
    localparam int unsigned TL_OFF   = 12;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HEADER  = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_PAD     = 3'd3;
    localparam logic [2:0] ST_IFG     = 3'd4;

    // Wire order is MSB first: dest_mac[47:40] is header byte 0
    typedef struct packed {
        logic [47:0] dest_mac;
        logic [47:0] src_mac;
        logic [15:0] type_length;
    } eth_hdr_t;

endpackage

// File: rtl/eth_hdr_serializer.sv
// Holds the latched 14-byte header and returns the byte selected by idx_i.
// While load_i is high the incoming header is selected so byte 0 leaves without a bubble.
module eth_hdr_serializer
    import eth_pkg::*;
(
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  eth_hdr_t         hdr_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [7:0]       byte_o
);

    logic [HDR_W-1:0] hdr_q;
    logic [HDR_W-1:0] sel;
    logic [HDR_W-1:0] shifted;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            hdr_q <= '0;
        end else if (load_i) begin
            hdr_q <= hdr_i;
        end
    end

    // Indices past the last header byte shift everything out and yield 00
    always_comb begin
        sel     = load_i ? hdr_i : hdr_q;
        shifted = sel << {idx_i, 3'b000};
        byte_o  = shifted[HDR_W-1 -: 8];
    end

endmodule

// File: rtl/eth_packet_tx.sv
// Ethernet frame byte-stream generator: header, payload from an upstream source,
// zero pad to the minimum payload, then an inter-frame gap.
module eth_packet_tx
    import eth_pkg::*;
#(
    parameter int unsigned MIN_PAYLOAD = MIN_PAYLOAD_DEF,
    parameter int unsigned MAX_PAYLOAD = MAX_PAYLOAD_DEF,
    parameter int unsigned IFG_CYCLES  = IFG_CYCLES_DEF
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [47:0]      dest_mac_i,
    input  logic [47:0]      src_mac_i,
    input  logic [15:0]      type_length_i,
    input  logic [LEN_W-1:0] payload_len_i,
    input  logic [7:0]       payload_data_i,
    input  logic             payload_valid_i,
    output logic             payload_ready_o,
    output logic             control_o,
    output logic [7:0]       data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    logic [2:0]       state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             aborted_q, aborted_d;
    logic             ctrl_q, ctrl_d;
    logic [7:0]       data_q, data_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             hdr_load;
    logic [IDX_W-1:0] hdr_idx;
    logic [7:0]       hdr_byte;
    eth_hdr_t         hdr_in;

    assign hdr_in = '{dest_mac: dest_mac_i, src_mac: src_mac_i, type_length: type_length_i};

    eth_hdr_serializer u_hdr (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .load_i  (hdr_load),
        .hdr_i   (hdr_in),
        .idx_i   (hdr_idx),
        .byte_o  (hdr_byte)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            aborted_q <= 1'b0;
            ctrl_q    <= 1'b0;
            data_q    <= 8'h00;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            aborted_q <= aborted_d;
            ctrl_q    <= ctrl_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Outputs are computed for the cycle after the edge; payload_ready therefore
    // rises while the last header byte is on the wire so payload follows without a gap.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        aborted_d = aborted_q;
        ctrl_d    = 1'b0;
        data_d    = 8'h00;
        ready_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        hdr_load  = 1'b0;
        hdr_idx   = cnt_q[IDX_W-1:0];

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (payload_len_i != '0 && payload_len_i <= LEN_W'(MAX_PAYLOAD)) begin
                        hdr_load  = 1'b1;
                        hdr_idx   = '0;
                        ctrl_d    = 1'b1;
                        data_d    = hdr_byte;
                        len_d     = payload_len_i;
                        cnt_d     = LEN_W'(1);
                        aborted_d = 1'b0;
                        state_d   = ST_HEADER;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_HEADER: begin
                ctrl_d = 1'b1;
                data_d = hdr_byte;
                cnt_d  = cnt_q + LEN_W'(1);
                if (cnt_q == LEN_W'(HDR_BYTES - 1)) begin
                    cnt_d   = '0;
                    ready_d = 1'b1;
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (payload_valid_i) begin
                    ctrl_d = 1'b1;
                    data_d = payload_data_i;
                    cnt_d  = cnt_q + LEN_W'(1);
                    if (cnt_d == len_q) begin
                        if (len_q < LEN_W'(MIN_PAYLOAD)) begin
                            cnt_d   = LEN_W'(MIN_PAYLOAD) - len_q;
                            state_d = ST_PAD;
                        end else begin
                            cnt_d   = '0;
                            state_d = ST_IFG;
                        end
                    end else begin
                        ready_d = 1'b1;
                    end
                end else begin
                    err_d     = 1'b1;
                    aborted_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_IFG;
                end
            end
            ST_PAD: begin
                ctrl_d = 1'b1;
                cnt_d  = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_IFG;
                end
            end
            ST_IFG: begin
                // One extra count leaves a visible idle cycle before start is sampled again
                cnt_d  = cnt_q + LEN_W'(1);
                done_d = (cnt_q == LEN_W'(IFG_CYCLES - 1)) && !aborted_q;
                if (cnt_q == LEN_W'(IFG_CYCLES)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign payload_ready_o = ready_q;
    assign control_o       = ctrl_q;
    assign data_o          = data_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign err_o           = err_q;

endmodule
